// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register. It drives the synchronous instruction ROM
// from PC, aligns the returned word with its PC, and raises the interrupt-take strobe.
module if_id_stage #(
   parameter int          IMEM_AW   = 8,
   parameter logic [31:0] NOP_INSTR = 32'h0
) (
   input  logic               CLK,
   input  logic               Reset_n,
   input  logic [31:0]        PC,
   input  logic [31:0]        PCplus4,
   input  logic               Stall,
   input  logic               Flush,
   input  logic               IRQ,
   input  logic [31:0]        imem_rdata,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        IFID_PC,
   output logic [31:0]        IFID_PCplus4,
   output logic [31:0]        IFID_Instr,
   output logic               IFID_Valid,
   output logic               IRQ_Take
);

   logic        hold_valid;
   logic [31:0] hold_instr;
   logic        irq_pending;
   logic        irq_d;
   logic        irq_rise;
   logic        kill;

   // Word address only: PC[31] is the privilege bit and PC[1:0] is the byte offset.
   assign imem_addr = PC[IMEM_AW+1:2];

   assign irq_rise = IRQ & ~irq_d;
   assign IRQ_Take = irq_pending & IFID_Valid & ~IFID_PC[31] & ~Stall & ~Flush;

   // Taking an interrupt discards the fetched instruction, exactly like a redirect.
   assign kill = Flush | IRQ_Take;

   // While the stage is stalled, the ROM has already moved on to the frozen PC, so
   // the word that belongs to IFID_PC exists only in hold_instr.
   assign IFID_Instr = !IFID_Valid ? NOP_INSTR :
                       hold_valid  ? hold_instr : imem_rdata;

   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         IFID_PC      <= 32'h0;
         IFID_PCplus4 <= 32'h0;
         IFID_Valid   <= 1'b0;
         hold_valid   <= 1'b0;
         hold_instr   <= 32'h0;
         irq_pending  <= 1'b0;
         irq_d        <= 1'b0;
      end else begin
         irq_d <= IRQ;

         // A new rising edge outranks the clear, so an edge seen while the interrupt
         // is being taken is not lost.
         if (irq_rise)
            irq_pending <= 1'b1;
         else if (IRQ_Take)
            irq_pending <= 1'b0;

         if (kill) begin
            // PC is still captured so that exception reporting sees the redirect PC.
            IFID_PC      <= PC;
            IFID_PCplus4 <= PCplus4;
            IFID_Valid   <= 1'b0;
            hold_valid   <= 1'b0;
         end else if (Stall) begin
            if (!hold_valid) begin
               hold_instr <= imem_rdata;
               hold_valid <= 1'b1;
            end
         end else begin
            IFID_PC      <= PC;
            IFID_PCplus4 <= PCplus4;
            IFID_Valid   <= 1'b1;
            hold_valid   <= 1'b0;
         end
      end
   end

endmodule
